// File: rtl/spi_flash_pkg.sv
// Shared constants for the UART-to-SPI-flash sequential writer.
// Contents: SPI opcodes, writer FSM state encoding, chip-select timing
// counts, SCK divider and FIFO depth, plus a helper that gives the
// chip-select-low length of a frame.
package spi_flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_PP   = 8'h02;

    typedef logic [2:0] wr_state_t;
    localparam wr_state_t ST_IDLE      = 3'd0;
    localparam wr_state_t ST_WREN      = 3'd1;
    localparam wr_state_t ST_GAP       = 3'd2;
    localparam wr_state_t ST_PP        = 3'd3;
    localparam wr_state_t ST_PROG_WAIT = 3'd4;

    localparam int CS_SETUP   = 4;   // cs_n low to first SCK bit period
    localparam int CS_HOLD    = 4;   // last bit period to cs_n high
    localparam int CS_GAP     = 8;   // cs_n high between WREN and PP
    localparam int SCK_DIV    = 4;   // sys_clk cycles per SCK period
    localparam int WREN_BITS  = 8;
    localparam int PP_BITS    = 40;
    localparam int FIFO_DEPTH = 16;

    // Number of cycles cs_n stays low for a frame of the given bit count.
    function automatic int frame_cycles(input int bits);
        return CS_SETUP + bits * SCK_DIV + CS_HOLD;
    endfunction

endpackage

// File: rtl/spi_flash_seq_writer_if.sv
// SPI flash bus bundle.
// Signals: sck (SPI clock, mode 0), cs_n (chip select, active low),
// mosi (serial data towards the flash).
// Modports: master drives the bus, slave observes it.
interface spi_flash_seq_writer_if;
    logic sck;
    logic cs_n;
    logic mosi;

    modport master (output sck, output cs_n, output mosi);
    modport slave  (input  sck, input  cs_n, input  mosi);
endinterface

// File: rtl/spi_flash_seq_writer_uart_rx.sv
// UART 8N1 byte receiver.
// Ports: sys_clk, sys_rst (sync, active high), rx (async serial input),
// rx_data[7:0] (received byte), rx_valid (1-cycle pulse per good byte).
// Each bit is sampled once at mid-period; bytes with a low stop bit are
// discarded without any indication.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 9600
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid
);
    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int BAUD_W   = $clog2(BAUD_CNT + 1);

    logic              rx_s1, rx_s2, rx_s3;
    logic              busy;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;    // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]        shift;
    logic              mid_bit;

    assign mid_bit = (baud_cnt == BAUD_W'(BAUD_CNT / 2));

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_valid <= 1'b0;
            if (!busy) begin
                if (rx_s3 && !rx_s2) begin
                    busy     <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            end else begin
                if (baud_cnt == BAUD_W'(BAUD_CNT - 1)) begin
                    baud_cnt <= '0;
                    bit_cnt  <= bit_cnt + 4'd1;
                end else begin
                    baud_cnt <= baud_cnt + BAUD_W'(1);
                end
                if (mid_bit) begin
                    if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8) begin
                        shift <= {rx_s2, shift[7:1]};
                    end else if (bit_cnt == 4'd9) begin
                        // Go idle at mid-stop so a back-to-back start edge is seen.
                        busy     <= 1'b0;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (rx_s2) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_seq_writer.sv
// UART-fed sequential SPI flash writer.
// Ports: sys_clk, sys_rst (sync, active high), rx (UART 8N1 input),
// spi (master modport: sck, cs_n, mosi).
// Every received byte is queued in a 16-entry FIFO, then written to the
// flash as WREN + page program (one byte per command) at an address that
// starts at START_ADDR and increments after each program wait.
module spi_flash_seq_writer
    import spi_flash_pkg::*;
#(
    parameter int          CLK_FREQ   = 50_000_000,
    parameter int          UART_BPS   = 9600,
    parameter logic [23:0] START_ADDR = 24'h00_04_25,
    parameter int          T_PROG     = 5000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   rx,
    spi_flash_seq_writer_if.master spi
);
    localparam int WREN_LEN = frame_cycles(WREN_BITS);
    localparam int PP_LEN   = frame_cycles(PP_BITS);
    localparam int CNT_MAX  = (T_PROG > PP_LEN) ? T_PROG : PP_LEN;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);

    logic [7:0] rx_data;
    logic       rx_valid;

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) u_rx (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rx      (rx),
        .rx_data (rx_data),
        .rx_valid(rx_valid)
    );

    // ---------------- FIFO ----------------
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;    // extra MSB separates full from empty
    logic        fifo_empty, fifo_full, push, pop;
    wr_state_t   state;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push       = rx_valid && !fifo_full;
    assign pop        = (state == ST_IDLE) && !fifo_empty;

    // NOTE: storage has no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // ---------------- writer FSM ----------------
    logic [CNT_W-1:0] cnt, last_cnt;
    logic [23:0]      addr;
    logic [7:0]       data_q;
    logic [39:0]      sh;           // outgoing frame, MSB on the wire first
    logic [1:0]       phase;        // position within an SCK period
    logic             shifting, bit_done, cs_n_d, sck_d, mosi_d;

    assign phase    = 2'(cnt - CNT_W'(CS_SETUP));
    assign shifting = (cnt >= CNT_W'(CS_SETUP)) &&
                      (((state == ST_WREN) && (cnt < CNT_W'(CS_SETUP + WREN_BITS * SCK_DIV))) ||
                       ((state == ST_PP)   && (cnt < CNT_W'(CS_SETUP + PP_BITS   * SCK_DIV))));
    assign bit_done = shifting && (phase == 2'd3);
    assign cs_n_d   = !((state == ST_WREN) || (state == ST_PP));
    assign sck_d    = shifting && phase[1];     // low for phases 0-1, high for 2-3
    assign mosi_d   = shifting && sh[39];       // changes only at phase 0

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        last_cnt = '0;
        case (state)
            ST_WREN:      last_cnt = CNT_W'(WREN_LEN - 1);
            ST_GAP:       last_cnt = CNT_W'(CS_GAP - 1);
            ST_PP:        last_cnt = CNT_W'(PP_LEN - 1);
            ST_PROG_WAIT: last_cnt = CNT_W'(T_PROG - 1);
            default:      last_cnt = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr     <= START_ADDR;
            data_q   <= '0;
            sh       <= '0;
            spi.sck  <= 1'b0;
            spi.cs_n <= 1'b1;
            spi.mosi <= 1'b0;
        end else begin
            // Pins are registered copies of the decoded state.
            spi.sck  <= sck_d;
            spi.cs_n <= cs_n_d;
            spi.mosi <= mosi_d;
            if (bit_done) sh <= {sh[38:0], 1'b0};

            if (state == ST_IDLE) begin
                if (!fifo_empty) begin
                    data_q <= fifo_mem[rd_ptr[AW-1:0]];
                    sh     <= {OP_WREN, 32'h0};
                    state  <= ST_WREN;
                    cnt    <= '0;
                end
            end else if (cnt == last_cnt) begin
                cnt <= '0;
                case (state)
                    ST_WREN: state <= ST_GAP;
                    ST_GAP: begin
                        state <= ST_PP;
                        sh    <= {OP_PP, addr, data_q};
                    end
                    ST_PP:   state <= ST_PROG_WAIT;
                    default: begin
                        addr  <= addr + 24'd1;
                        state <= ST_IDLE;
                    end
                endcase
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_seq_writer.sv
// Self-checking bench for spi_flash_seq_writer.
// dut_a: 500 kHz clock, 9600 Bd (52 cycles/bit), short program wait.
//        Directed vector table, reset-during-PP sequence, then a random
//        stream of 100 good bytes with random framing errors mixed in.
// dut_b: 62500 Bd (8 cycles/bit), long program wait, start address at
//        the top of the 24-bit space; a 20-byte burst overflows the FIFO.
// A flash monitor per bus decodes WREN/PP frames and checks SCK timing.
module tb_spi_flash_seq_writer;

    localparam int          BIT_A   = 52;
    localparam int          BIT_B   = 8;
    localparam logic [23:0] START_A = 24'h00_04_25;
    localparam logic [23:0] START_B = 24'hFF_FFFF;
    localparam int          DEPTH   = 16;

    logic clk = 1'b0;
    logic rst_a, rst_b, rx_a, rx_b;

    spi_flash_seq_writer_if bus_a ();
    spi_flash_seq_writer_if bus_b ();

    spi_flash_seq_writer #(.CLK_FREQ(500_000), .UART_BPS(9600), .START_ADDR(START_A), .T_PROG(100))
        dut_a (.sys_clk(clk), .sys_rst(rst_a), .rx(rx_a), .spi(bus_a));
    spi_flash_seq_writer #(.CLK_FREQ(500_000), .UART_BPS(62_500), .START_ADDR(START_B), .T_PROG(1600))
        dut_b (.sys_clk(clk), .sys_rst(rst_b), .rx(rx_b), .spi(bus_b));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int frames_a = 0, frames_b = 0;
    int idle_err_a = 0, idle_err_b = 0;
    bit abort_a = 1'b0;
    logic [31:0] act_q_a [$];   // {addr[23:0], data[7:0]} per programmed byte
    logic [31:0] act_q_b [$];

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic        exp_prog;
        logic [23:0] exp_addr;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_rx(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    // One 8N1 frame, LSB first; line left idle high afterwards.
    task automatic send(input int which, input logic [7:0] b, input logic stop_bit, input int bit_cyc);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive_rx(which, fr[i]);
            repeat (bit_cyc) @(negedge clk);
        end
        drive_rx(which, 1'b1);
    endtask

    // Flash-side monitor: samples on the falling clock edge.
    task automatic monitor(input int which);
        logic        cs, sck, mosi;
        logic        p_cs = 1'b1, p_sck = 1'b0, p_mosi = 1'b0, wren_ok = 1'b0;
        logic [39:0] bits = '0;
        int          nbits = 0, cyc = 0, last_rise = 0, per_err = 0, mosi_err = 0;
        forever begin
            @(negedge clk);
            if (which == 0) begin cs = bus_a.cs_n; sck = bus_a.sck; mosi = bus_a.mosi; end
            else            begin cs = bus_b.cs_n; sck = bus_b.sck; mosi = bus_b.mosi; end
            if (!cs) begin
                if (p_cs) begin
                    bits = '0; nbits = 0; cyc = 0; last_rise = 0; per_err = 0; mosi_err = 0;
                    if (which == 0) frames_a++; else frames_b++;
                end
                cyc++;
                if (sck && !p_sck) begin
                    if (nbits > 0 && cyc - last_rise != 4) per_err++;
                    if (mosi != p_mosi) mosi_err++;
                    last_rise = cyc;
                    bits      = {bits[38:0], mosi};
                    nbits++;
                end else if (sck && p_sck && mosi != p_mosi) begin
                    mosi_err++;
                end
            end else begin
                if (sck) begin
                    if (which == 0) idle_err_a++; else idle_err_b++;
                end
                if (!p_cs) begin
                    if (which == 0 && abort_a) begin
                        wren_ok = 1'b0;
                    end else begin
                        check("sck_period", 64'(per_err), 0);
                        check("mosi_stable", 64'(mosi_err), 0);
                        check("cs_low_cycles", 64'(cyc), 64'(8 + 4 * nbits));
                        if (nbits == 8) begin
                            check("wren_opcode", bits[7:0], 8'h06);
                            wren_ok = 1'b1;
                        end else if (nbits == 40) begin
                            check("pp_after_wren", wren_ok, 1'b1);
                            check("pp_opcode", bits[39:32], 8'h02);
                            if (which == 0) act_q_a.push_back(bits[31:0]);
                            else            act_q_b.push_back(bits[31:0]);
                            wren_ok = 1'b0;
                        end else begin
                            check("frame_bits", 64'(nbits), 40);
                        end
                    end
                end
            end
            p_cs = cs; p_sck = sck; p_mosi = mosi;
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 24'h00_0425};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 24'h00_0000};   // framing error
        vecs[2] = '{8'h00, 1'b1, 1'b1, 24'h00_0426};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 24'h00_0427};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 24'h00_0000};   // framing error
        vecs[5] = '{8'h7E, 1'b1, 1'b1, 24'h00_0428};

        rst_a = 1'b1; rst_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_cs_n_a", bus_a.cs_n, 1'b1);
        check("rst_sck_a",  bus_a.sck,  1'b0);
        check("rst_mosi_a", bus_a.mosi, 1'b0);
        check("rst_cs_n_b", bus_b.cs_n, 1'b1);
        rst_a = 1'b0; rst_b = 1'b0;

        fork
            monitor(0);
            monitor(1);
        join_none

        fork
            // ---------------- dut_a ----------------
            begin
                int f0;
                logic [7:0]  b;
                logic [31:0] exp_q [$];
                int n_good;

                for (int i = 0; i < 6; i++) begin
                    f0 = frames_a;
                    act_q_a.delete();
                    send(0, vecs[i].data, vecs[i].stop, BIT_A);
                    for (int c = 0; c < 2000 && act_q_a.size() == 0; c++) @(negedge clk);
                    check($sformatf("vec%0d_writes", i), 64'(act_q_a.size()), 64'(vecs[i].exp_prog));
                    check($sformatf("vec%0d_frames", i), 64'(frames_a - f0), vecs[i].exp_prog ? 2 : 0);
                    if (vecs[i].exp_prog && act_q_a.size() == 1)
                        check($sformatf("vec%0d_addr_data", i), act_q_a[0], {vecs[i].exp_addr, vecs[i].data});
                end

                // Reset in the middle of the PP shift.
                f0 = frames_a;
                act_q_a.delete();
                send(0, 8'hC3, 1'b1, BIT_A);
                for (int c = 0; c < 2000 && frames_a - f0 < 2; c++) @(negedge clk);
                check("rst_pp_started", 64'(frames_a - f0), 2);
                repeat (60) @(negedge clk);
                abort_a = 1'b1;
                rst_a   = 1'b1;
                @(posedge clk); #1;
                check("midrst_cs_n", bus_a.cs_n, 1'b1);
                check("midrst_sck",  bus_a.sck,  1'b0);
                check("midrst_mosi", bus_a.mosi, 1'b0);
                @(negedge clk);
                rst_a = 1'b0;
                repeat (4) @(negedge clk);
                abort_a = 1'b0;
                repeat (300) @(negedge clk);
                check("midrst_no_write", 64'(act_q_a.size()), 0);
                send(0, 8'h5A, 1'b1, BIT_A);
                for (int c = 0; c < 2000 && act_q_a.size() == 0; c++) @(negedge clk);
                check("post_rst_writes", 64'(act_q_a.size()), 1);
                if (act_q_a.size() == 1) check("post_rst_addr_data", act_q_a[0], {START_A, 8'h5A});

                // Random back-to-back stream; bad frames never consume an address.
                repeat (300) @(negedge clk);
                rst_a = 1'b1;
                repeat (2) @(negedge clk);
                rst_a = 1'b0;
                act_q_a.delete();
                n_good = 0;
                while (n_good < 100) begin
                    b = 8'($urandom);
                    if ($urandom_range(0, 15) == 0) begin
                        send(0, b, 1'b0, BIT_A);
                        repeat (2 * BIT_A) @(negedge clk);
                    end else begin
                        send(0, b, 1'b1, BIT_A);
                        exp_q.push_back({24'(START_A + 24'(n_good)), b});
                        n_good++;
                    end
                end
                for (int c = 0; c < 3000 && act_q_a.size() < 100; c++) @(negedge clk);
                check("stream_count", 64'(act_q_a.size()), 100);
                for (int k = 0; k < 100 && k < act_q_a.size(); k++)
                    check($sformatf("stream_%0d", k), act_q_a[k], exp_q[k]);
            end

            // ---------------- dut_b ----------------
            begin
                logic [7:0] bytes_b [20];
                int kept;
                for (int i = 0; i < 20; i++) begin
                    bytes_b[i] = 8'($urandom);
                    send(1, bytes_b[i], 1'b1, BIT_B);
                end
                // The first byte is popped at once and is still being
                // programmed when the burst ends; the FIFO then holds the
                // next DEPTH bytes and everything after is dropped.
                kept = 1 + DEPTH;
                for (int c = 0; c < 40000 && act_q_b.size() < kept; c++) @(negedge clk);
                repeat (2500) @(negedge clk);
                check("ovf_count", 64'(act_q_b.size()), 64'(kept));
                for (int k = 0; k < kept && k < act_q_b.size(); k++)
                    check($sformatf("ovf_%0d", k), act_q_b[k], {24'(START_B + 24'(k)), bytes_b[k]});
            end
        join

        check("sck_idle_low_a", 64'(idle_err_a), 0);
        check("sck_idle_low_b", 64'(idle_err_b), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
